// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between an issuing pipeline stage and mul_div_unit.
//   Start      : request, sampled only while the unit is not busy
//   Kill       : abort whatever is in flight (pipeline flush)
//   SrcA/SrcB  : operands (multiplicand/dividend, multiplier/divisor)
//   Operation  : funct3 code, 000 MUL .. 111 REMU
//   Busy       : operation in flight, new Start ignored
//   Done       : one-cycle pulse, MDResult valid
//   MDResult   : result, held until the next accepted Start completes
// The issuing side uses the master modport, the arithmetic unit the slave one.
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic                  Kill;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic [2:0]            Operation;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] MDResult;

  modport master (
    output Start, Kill, SrcA, SrcB, Operation,
    input  Busy, Done, MDResult
  );

  modport slave (
    input  Start, Kill, SrcA, SrcB, Operation,
    output Busy, Done, MDResult
  );
endinterface

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative RISC-V M-extension style multiply/divide unit.
//   - Multiply: shift-add on operand magnitudes, one multiplier bit per cycle.
//   - Divide:   restoring division on operand magnitudes, one quotient bit per
//               cycle. Signs are applied when the result is written.
//   - Divide-by-zero and signed overflow take a one-cycle fast path.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mul_div_unit_if.slave (Start, Kill, SrcA, SrcB, Operation in;
//           Busy, Done, MDResult out)
// Busy/Done/MDResult are all driven straight from registers.
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input logic            clk,
  input logic            reset,
  mul_div_unit_if.slave  bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     ALL_ONES  = {W{1'b1}};
  localparam logic [W-1:0]     ALL_ZERO  = {W{1'b0}};

  localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = 3'b000;
  localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = 3'b001;
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = 3'b010;
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = 3'b011;
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = 3'b100;
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = 3'b101;
  localparam logic [OPCODE_LENGTH-1:0] OP_REM    = 3'b110;
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01,
    DIV_RUN = 2'b10,
    FINISH  = 2'b11
  } state_t;

  // Architectural state
  state_t                     state_q,  state_d;
  logic [CNT_W-1:0]           cnt_q,    cnt_d;
  logic [OPCODE_LENGTH-1:0]   op_q,     op_d;
  logic                       neg_q,    neg_d;   // negate final result
  logic [W-1:0]               opb_q,    opb_d;   // multiplicand or divisor magnitude
  logic [2*W-1:0]             acc_q,    acc_d;   // {hi, lo} working register
  logic [W-1:0]               res_q,    res_d;
  logic                       busy_q,   busy_d;
  logic                       done_q,   done_d;

  // Accept-time operand decode
  logic                       accept;
  logic                       sgn_a, sgn_b;
  logic                       neg_a, neg_b;
  logic [W-1:0]               a_use, b_use;
  logic                       res_neg;
  logic                       div_zero, div_ovf;

  // Iteration datapath
  logic [W:0]                 mul_sum;
  logic [2*W-1:0]             mul_next;
  logic [W:0]                 div_shift;
  logic [W+1:0]               div_diff;
  logic [2*W-1:0]             div_next;
  logic [2*W-1:0]             prod_fin;
  logic [W-1:0]               quo_raw, rem_raw;
  logic [W-1:0]               fin_res;
  logic                       unused_diff_bit;

  // A request is only taken when idle or finishing; Kill always wins.
  assign accept = ((state_q == IDLE) || (state_q == FINISH)) && bus.Start && !bus.Kill;

  // Decode signedness of the incoming request and build operand magnitudes.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.Operation)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      OP_MULHSU: begin
        sgn_a = 1'b1;
        sgn_b = 1'b0;
      end
      default: begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
      end
    endcase
    neg_a = sgn_a & bus.SrcA[W-1];
    neg_b = sgn_b & bus.SrcB[W-1];
    a_use = neg_a ? -bus.SrcA : bus.SrcA;
    b_use = neg_b ? -bus.SrcB : bus.SrcB;
    // Remainder follows the dividend sign; everything else is sign(A) xor sign(B).
    res_neg  = (bus.Operation == OP_REM) ? neg_a : (neg_a ^ neg_b);
    div_zero = bus.Operation[2] && (bus.SrcB == ALL_ZERO);
    // Only the signed forms (DIV, REM) have bit 0 clear.
    div_ovf  = bus.Operation[2] && !bus.Operation[0] &&
               (bus.SrcA == MOST_NEG) && (bus.SrcB == ALL_ONES);
  end

  // One shift-add step (hi += lo[0] ? mcand : 0, then shift right) and one
  // restoring-division step (shift remainder left, trial subtract).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    if (div_diff[W+1]) begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
    // After a successful subtraction the remainder is below the divisor, so this bit is zero.
    unused_diff_bit = div_diff[W];
  end

  // Sign correction and half selection for the value written on the last iteration.
  always_comb begin
    prod_fin = neg_q ? -mul_next : mul_next;
    quo_raw  = div_next[W-1:0];
    rem_raw  = div_next[2*W-1:W];
    case (op_q)
      OP_MUL:                      fin_res = prod_fin[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fin[2*W-1:W];
      OP_DIV, OP_DIVU:             fin_res = neg_q ? -quo_raw : quo_raw;
      OP_REM, OP_REMU:             fin_res = neg_q ? -rem_raw : rem_raw;
      default:                     fin_res = ALL_ZERO;
    endcase
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;

    if (bus.Kill) begin
      // Flush: drop the operation, leave the last result untouched.
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          if (accept) begin
            op_d  = bus.Operation;
            neg_d = res_neg;
            cnt_d = {CNT_W{1'b0}};
            if (bus.Operation[2]) begin
              opb_d = b_use;
              acc_d = {ALL_ZERO, a_use};
            end else begin
              opb_d = a_use;
              acc_d = {ALL_ZERO, b_use};
            end
            if (div_zero) begin
              state_d = FINISH;
              res_d   = bus.Operation[1] ? bus.SrcA : ALL_ONES;
            end else if (div_ovf) begin
              state_d = FINISH;
              res_d   = bus.Operation[1] ? ALL_ZERO : bus.SrcA;
            end else if (bus.Operation[2]) begin
              state_d = DIV_RUN;
            end else begin
              state_d = MUL_RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        MUL_RUN: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_ITER) begin
            state_d = FINISH;
            res_d   = fin_res;
          end else begin
            state_d = MUL_RUN;
          end
        end
        DIV_RUN: begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_ITER) begin
            state_d = FINISH;
            res_d   = fin_res;
          end else begin
            state_d = DIV_RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == MUL_RUN) || (state_d == DIV_RUN);
    done_d = (state_d == FINISH);
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= {OPCODE_LENGTH{1'b0}};
      neg_q   <= 1'b0;
      opb_q   <= ALL_ZERO;
      acc_q   <= {2*W{1'b0}};
      res_q   <= ALL_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.MDResult = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed bench for mul_div_unit (DATA_WIDTH = 32). Inputs are driven and
// outputs sampled on the falling clock edge. Latency is counted in falling
// edges after the accepting rising edge: the first falling edge is 1.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   lat;
  int   bcnt;

  mul_div_unit_if #(.DATA_WIDTH(W)) bus ();

  mul_div_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request now, then clear it (and scramble operands) one falling edge later.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.Start     = 1'b1;
    @(negedge clk);
    bus.Start     = 1'b0;
    bus.Operation = 3'b111;
    bus.SrcA      = 32'hDEAD_BEEF;
    bus.SrcB      = 32'h1234_5678;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(op, a, b);
  endtask

  // Bounded wait for Done; lat = 0 means it never came.
  task automatic wait_done(output int l, output int busy_cycles);
    l = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.Busy === 1'b1) busy_cycles++;
      if (bus.Done === 1'b1) begin
        l = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    checks++; if (bus.MDResult !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", bus.MDResult); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++; if (bcnt !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", bcnt); end
    checks++; if (bus.MDResult !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", bus.MDResult); end
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", bus.Done); end
    checks++; if (bus.MDResult !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h want ffffffeb", bus.MDResult); end
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{OP_MULHU, OP_MULH, OP_MULHSU};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      checks++; if (lat !== 33) begin errors++; $display("FAIL mulh_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (bus.MDResult !== exp[i]) begin errors++; $display("FAIL mulh_result[%0d]: got %h want %h", i, bus.MDResult, exp[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_done(lat, bcnt);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (bus.MDResult !== exp[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, bus.MDResult, exp[i]); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_done(lat, bcnt);
      checks++; if (lat !== 1) begin errors++; $display("FAIL fast_latency[%0d]: got %0d want 1", i, lat); end
      checks++; if (bus.MDResult !== exp[i]) begin errors++; $display("FAIL fast_result[%0d]: got %h want %h", i, bus.MDResult, exp[i]); end
    end
    // Consecutive fast-path operations: Done stays high on adjacent cycles.
    start_op(OP_DIVU, 32'd5, 32'd0);
    wait_done(lat, bcnt);
    issue(OP_REMU, 32'd9, 32'd0);
    wait_done(lat, bcnt);
    checks++; if (lat !== 1) begin errors++; $display("FAIL fast_b2b_latency: got %0d want 1", lat); end
    checks++; if (bus.MDResult !== 32'd9) begin errors++; $display("FAIL fast_b2b_result: got %h want 00000009", bus.MDResult); end
  endtask

  task automatic test_busy_ignore();
    start_op(OP_MUL, 32'd3, 32'd7);
    repeat (9) @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    checks++; if (lat !== 23) begin errors++; $display("FAIL ignore_latency: got %0d want 23", lat); end
    checks++; if (bus.MDResult !== 32'd21) begin errors++; $display("FAIL ignore_result: got %h want 00000015", bus.MDResult); end
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got busy %b want 0", bus.Busy); end
  endtask

  task automatic test_kill();
    int done_seen;
    start_op(OP_MUL, 32'd3, 32'd3);
    repeat (4) @(negedge clk);
    bus.Kill = 1'b1;
    @(negedge clk);
    bus.Kill = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b want 0", bus.Busy); end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1) done_seen++;
      @(negedge clk);
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL kill_no_done: got %0d done cycles want 0", done_seen); end
    checks++; if (bus.MDResult !== 32'd21) begin errors++; $display("FAIL kill_result_kept: got %h want 00000015", bus.MDResult); end
    // Kill and Start together: nothing accepted.
    bus.Operation = OP_MUL;
    bus.SrcA      = 32'd2;
    bus.SrcB      = 32'd2;
    bus.Start     = 1'b1;
    bus.Kill      = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Kill  = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL kill_start_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_back_to_back();
    start_op(OP_MUL, 32'd5, 32'd6);
    wait_done(lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", lat); end
    checks++; if (bus.MDResult !== 32'd30) begin errors++; $display("FAIL b2b_first_result: got %h want 0000001e", bus.MDResult); end
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
    checks++; if (bus.MDResult !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_second_result: got %h want fffffffe", bus.MDResult); end
  endtask

  task automatic test_reset_mid_op();
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", bus.Done); end
    checks++; if (bus.MDResult !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 00000000", bus.MDResult); end
    @(negedge clk);
    // Start already present at the first rising edge after release.
    reset = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rst_release_latency: got %0d want 33", lat); end
    checks++; if (bus.MDResult !== 32'd14) begin errors++; $display("FAIL rst_release_result: got %h want 0000000e", bus.MDResult); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.Start     = 1'b0;
    bus.Kill      = 1'b0;
    bus.SrcA      = 32'h0;
    bus.SrcB      = 32'h0;
    bus.Operation = 3'b000;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_busy_ignore();
    test_kill();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
